// File: rtl/ysyx_22050598_wbu_pkg.sv
// ysyx_22050598_wbu_pkg: writeback FSM states and load-type funct3 encodings
package ysyx_22050598_wbu_pkg;
  typedef enum logic [1:0] {IDLE, WAIT_MEM, WRITE} state_t;
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;
endpackage

// File: rtl/ysyx_22050598_wbu_if.sv
// ysyx_22050598_wbu_if: execute-to-writeback handshake and result bundle
interface ysyx_22050598_wbu_if;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic        in_rd_wen;
  logic        in_is_load;
  logic [63:0] in_alu_res;
  logic [2:0]  in_ld_funct3;
  logic [2:0]  in_ld_off;
  modport master (output in_valid, in_rd, in_rd_wen, in_is_load, in_alu_res, in_ld_funct3, in_ld_off, input in_ready);
  modport slave (input in_valid, in_rd, in_rd_wen, in_is_load, in_alu_res, in_ld_funct3, in_ld_off, output in_ready);
endinterface

// File: rtl/ysyx_22050598_load_ext.sv
// ysyx_22050598_load_ext: selects and sign/zero-extends load data from an aligned doubleword
module ysyx_22050598_load_ext
  import ysyx_22050598_wbu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [2:0]  off,
  input  logic [63:0] rdata,
  output logic [63:0] data
);
  logic [2:0]  lane;
  logic [63:0] sh;
  always_comb begin
    lane = (funct3[1:0] == 2'b01) ? {off[2:1], 1'b0} : (funct3[1:0] == 2'b10) ? {off[2], 2'b00} : off;
    sh   = rdata >> {lane, 3'b000};
    data = (funct3 == F3_LB)  ? {{56{sh[7]}}, sh[7:0]} :
           (funct3 == F3_LH)  ? {{48{sh[15]}}, sh[15:0]} :
           (funct3 == F3_LW)  ? {{32{sh[31]}}, sh[31:0]} :
           (funct3 == F3_LBU) ? {56'd0, sh[7:0]} :
           (funct3 == F3_LHU) ? {48'd0, sh[15:0]} :
           (funct3 == F3_LWU) ? {32'd0, sh[31:0]} : rdata;
  end
endmodule

// File: rtl/ysyx_22050598_wbu.sv
// ysyx_22050598_wbu: writeback unit; YSYX_22050598_WB_BYPASS_EN adds byp_* forwarding outputs
module ysyx_22050598_wbu
  import ysyx_22050598_wbu_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  ysyx_22050598_wbu_if.slave         in_if,
  input  logic                       mem_rvalid,
  input  logic [63:0]                mem_rdata,
  output logic                       rf_wen,
  output logic [4:0]                 rf_waddr,
  output logic [63:0]                rf_wdata,
`ifdef YSYX_22050598_WB_BYPASS_EN
  output logic                       byp_valid,
  output logic [4:0]                 byp_rd,
  output logic [63:0]                byp_data,
`endif
  output logic                       commit
);
  state_t      state;
  logic [4:0]  rd_q;
  logic        wen_q;
  logic [2:0]  f3_q;
  logic [2:0]  off_q;
  logic [63:0] ld_data;
  assign in_if.in_ready = state == IDLE;
  ysyx_22050598_load_ext u_ext (.funct3(f3_q), .off(off_q), .rdata(mem_rdata), .data(ld_data));
`ifdef YSYX_22050598_WB_BYPASS_EN
  assign byp_valid = rf_wen;
  assign byp_rd    = rf_waddr;
  assign byp_data  = rf_wdata;
`endif
  // rf_wen/commit are only ever raised on entry to WRITE, so they pulse for exactly that cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rf_wen   <= 1'b0;
      commit   <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      rd_q     <= '0;
      wen_q    <= 1'b0;
      f3_q     <= '0;
      off_q    <= '0;
    end else begin
      case (state)
        IDLE: if (in_if.in_valid) begin
          rd_q  <= in_if.in_rd;
          wen_q <= in_if.in_rd_wen;
          f3_q  <= in_if.in_ld_funct3;
          off_q <= in_if.in_ld_off;
          if (in_if.in_is_load) state <= WAIT_MEM;
          else begin
            state    <= WRITE;
            rf_wen   <= in_if.in_rd_wen & |in_if.in_rd;
            rf_waddr <= in_if.in_rd;
            rf_wdata <= in_if.in_alu_res;
            commit   <= 1'b1;
          end
        end
        WAIT_MEM: if (mem_rvalid) begin
          state    <= WRITE;
          rf_wen   <= wen_q & |rd_q;
          rf_waddr <= rd_q;
          rf_wdata <= ld_data;
          commit   <= 1'b1;
        end
        WRITE: begin
          state  <= IDLE;
          rf_wen <= 1'b0;
          commit <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ysyx_22050598_wbu.sv
// tb_ysyx_22050598_wbu: directed self-checking bench for the writeback unit
module tb_ysyx_22050598_wbu;
  logic        clk = 1'b0;
  logic        rst;
  logic        mem_rvalid;
  logic [63:0] mem_rdata;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [63:0] rf_wdata;
  logic        commit;
  int          errors = 0;
  int          checks = 0;
`ifdef YSYX_22050598_WB_BYPASS_EN
  logic        byp_valid;
  logic [4:0]  byp_rd;
  logic [63:0] byp_data;
`endif
  ysyx_22050598_wbu_if bus ();
  ysyx_22050598_wbu dut (
    .clk(clk), .rst(rst), .in_if(bus.slave), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
`ifdef YSYX_22050598_WB_BYPASS_EN
    .byp_valid(byp_valid), .byp_rd(byp_rd), .byp_data(byp_data),
`endif
    .commit(commit)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic do_load(input string tag, input logic [2:0] f3, input logic [2:0] off, input logic [63:0] data, input logic [63:0] exp);
    bus.in_valid     = 1'b1;
    bus.in_is_load   = 1'b1;
    bus.in_rd        = 5'd9;
    bus.in_rd_wen    = 1'b1;
    bus.in_ld_funct3 = f3;
    bus.in_ld_off    = off;
    mem_rvalid       = 1'b1;
    mem_rdata        = data;
    step();
    check({tag, "_hs_commit"}, {63'd0, commit}, 64'd0);
    check({tag, "_wait_ready"}, {63'd0, bus.in_ready}, 64'd0);
    bus.in_valid = 1'b0;
    step();
    check({tag, "_data"}, rf_wdata, exp);
    check({tag, "_commit"}, {63'd0, commit}, 64'd1);
    check({tag, "_wen"}, {63'd0, rf_wen}, 64'd1);
    mem_rvalid = 1'b0;
    step();
  endtask
  initial begin
    rst = 1'b1;
    mem_rvalid = 1'b0;
    mem_rdata = '0;
    bus.in_valid = 1'b0;
    bus.in_rd = '0;
    bus.in_rd_wen = 1'b0;
    bus.in_is_load = 1'b0;
    bus.in_alu_res = '0;
    bus.in_ld_funct3 = '0;
    bus.in_ld_off = '0;
    step();
    step();
    check("rst_wen", {63'd0, rf_wen}, 64'd0);
    check("rst_commit", {63'd0, commit}, 64'd0);
    check("rst_waddr", {59'd0, rf_waddr}, 64'd0);
    check("rst_wdata", rf_wdata, 64'd0);
    check("rst_ready", {63'd0, bus.in_ready}, 64'd1);
    rst = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_rd = 5'd5;
    bus.in_rd_wen = 1'b1;
    bus.in_alu_res = 64'h1234;
    step();
    check("alu_wen", {63'd0, rf_wen}, 64'd1);
    check("alu_waddr", {59'd0, rf_waddr}, 64'd5);
    check("alu_wdata", rf_wdata, 64'h1234);
    check("alu_commit", {63'd0, commit}, 64'd1);
    check("alu_ready_write", {63'd0, bus.in_ready}, 64'd0);
    bus.in_valid = 1'b0;
    step();
    check("alu_ready_after", {63'd0, bus.in_ready}, 64'd1);
    check("alu_commit_after", {63'd0, commit}, 64'd0);
    check("alu_wen_after", {63'd0, rf_wen}, 64'd0);
    check("alu_waddr_hold", {59'd0, rf_waddr}, 64'd5);
    check("alu_wdata_hold", rf_wdata, 64'h1234);
    do_load("lb", 3'b000, 3'd3, 64'h00000000_80000000, 64'hFFFFFFFF_FFFFFF80);
    do_load("lbu", 3'b100, 3'd3, 64'h00000000_80000000, 64'h80);
    do_load("lw", 3'b010, 3'd4, 64'h87654321_00000000, 64'hFFFFFFFF_87654321);
    do_load("lwu", 3'b110, 3'd4, 64'h87654321_00000000, 64'h87654321);
    do_load("lh", 3'b001, 3'd2, 64'h00000000_80010000, 64'hFFFFFFFF_FFFF8001);
    do_load("lhu_odd", 3'b101, 3'd3, 64'h00000000_ABCD0000, 64'hABCD);
    do_load("ld", 3'b011, 3'd5, 64'h01234567_89ABCDEF, 64'h01234567_89ABCDEF);
    do_load("f3_111", 3'b111, 3'd1, 64'hFEDCBA98_76543210, 64'hFEDCBA98_76543210);
    bus.in_valid = 1'b1;
    bus.in_is_load = 1'b0;
    bus.in_rd = 5'd0;
    bus.in_rd_wen = 1'b1;
    bus.in_alu_res = 64'hDEAD;
    step();
    check("x0_wen", {63'd0, rf_wen}, 64'd0);
    check("x0_commit", {63'd0, commit}, 64'd1);
    bus.in_rd = 5'd3;
    bus.in_rd_wen = 1'b0;
    step();
    step();
    check("nowen_wen", {63'd0, rf_wen}, 64'd0);
    check("nowen_commit", {63'd0, commit}, 64'd1);
    check("nowen_waddr", {59'd0, rf_waddr}, 64'd3);
    bus.in_valid = 1'b0;
    step();
    bus.in_valid = 1'b1;
    bus.in_is_load = 1'b1;
    bus.in_rd = 5'd7;
    bus.in_rd_wen = 1'b1;
    bus.in_ld_funct3 = 3'b011;
    mem_rvalid = 1'b0;
    mem_rdata = 64'h5555;
    step();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("stall_ready", {63'd0, bus.in_ready}, 64'd0);
      check("stall_commit", {63'd0, commit}, 64'd0);
      step();
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_ready", {63'd0, bus.in_ready}, 64'd1);
    check("abort_waddr", {59'd0, rf_waddr}, 64'd0);
    mem_rvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("abort_commit", {63'd0, commit}, 64'd0);
      check("abort_wen", {63'd0, rf_wen}, 64'd0);
      check("abort_wdata", rf_wdata, 64'd0);
    end
    mem_rvalid = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_is_load = 1'b0;
    bus.in_rd_wen = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.in_rd = 5'(k + 1);
      bus.in_alu_res = 64'h100 + 64'(k);
      step();
      check("b2b_commit", {63'd0, commit}, 64'd1);
      check("b2b_waddr", {59'd0, rf_waddr}, 64'(k + 1));
      check("b2b_wdata", rf_wdata, 64'h100 + 64'(k));
`ifdef YSYX_22050598_WB_BYPASS_EN
      check("byp_valid", {63'd0, byp_valid}, 64'd1);
      check("byp_data", byp_data, 64'h100 + 64'(k));
`endif
      bus.in_rd = 5'd31;
      bus.in_alu_res = 64'hBAD;
      step();
      check("b2b_gap_commit", {63'd0, commit}, 64'd0);
      check("b2b_gap_ready", {63'd0, bus.in_ready}, 64'd1);
    end
    bus.in_valid = 1'b0;
    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ysyx_22050598_wbu.md
YSYX_22050598_WBU -- requirements
Module: ysyx_22050598_wbu

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, all state on rising edge.
REQ-002 SHALL have ports: rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have ports: in_valid  in  1  execute result offered.
REQ-004 SHALL have ports: in_ready  out  1  wbu can accept.
REQ-005 SHALL have ports: in_rd  in  5  destination register.
REQ-006 SHALL have ports: in_rd_wen  in  1  instruction writes rd.
REQ-007 SHALL have ports: in_is_load  in  1  result comes from memory, not ALU.
REQ-008 SHALL have ports: in_alu_res  in  64  ALU result.
REQ-009 SHALL have ports: in_ld_funct3  in  3  load type.
REQ-010 SHALL have ports: in_ld_off  in  3  load address bits [2:0].
REQ-011 SHALL have ports: mem_rvalid  in  1  load data returned.
REQ-012 SHALL have ports: mem_rdata  in  64  aligned doubleword.
REQ-013 SHALL have ports: rf_wen  out  1, rf_waddr  out  5, rf_wdata  out  64  register-file write port.
REQ-014 SHALL have ports: commit  out  1  one-cycle pulse per retired instruction.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT_MEM, WRITE.
REQ-016 SHALL drive in_ready=1 only in IDLE; handshake = in_valid & in_ready.
REQ-017 On handshake with in_is_load=0, SHALL latch rd/wen/alu_res and go to WRITE (result at rf port exactly 1 cycle after handshake).
REQ-018 On handshake with in_is_load=1, SHALL latch rd/wen/funct3/off and go to WAIT_MEM.
REQ-019 In WAIT_MEM, SHALL stay until mem_rvalid=1, then latch extracted data and go to WRITE; mem_rvalid in the same cycle as the load handshake SHALL be ignored.
REQ-020 In WRITE, SHALL assert rf_wen=(latched wen & rd!=0), rf_waddr, rf_wdata and commit=1 for exactly one cycle, then return to IDLE.
REQ-021 Load extraction: byte lane=off*8; funct3 000 lb, 001 lh, 010 lw: sign-extend to 64 bits; 100 lbu, 101 lhu, 110 lwu: zero-extend to 64 bits; 011 and 111: full 64 bits.
REQ-022 SHALL ignore the unused upper offset bits for halfword/word loads (no misalignment check).
REQ-023 Outside WRITE, SHALL hold rf_wen=0 and commit=0; rf_waddr/rf_wdata SHALL hold their last values.
REQ-024 SHALL ignore mem_rvalid in IDLE and WRITE.

Reset
REQ-025 rst SHALL force state=IDLE, rf_wen=0, commit=0, rf_waddr=0, rf_wdata=0, in_ready=1 on the next edge.
REQ-026 rst in WAIT_MEM or WRITE SHALL drop the in-flight instruction without a write or commit.

Configuration
REQ-027 With YSYX_22050598_WB_BYPASS_EN defined, SHALL add outputs byp_valid(1), byp_rd(5), byp_data(64), equal combinationally to the WRITE-cycle rf_wen/rf_waddr/rf_wdata, for forwarding to operand read.
REQ-028 Without YSYX_22050598_WB_BYPASS_EN, those ports SHALL be absent and behaviour otherwise identical.

Structure
REQ-029 Package ysyx_22050598_wbu_pkg SHALL hold the state enum and the funct3 load-type constants.
REQ-030 Load extraction SHALL be a combinational sub-module ysyx_22050598_load_ext(funct3, off, rdata -> data).

Verification
REQ-031 ALU: in_alu_res=0x1234, rd=5, wen=1, handshake at cycle N -> cycle N+1: rf_wen=1, waddr=5, wdata=0x1234, commit=1; in_ready=1 at N+2.
REQ-032 lb: off=3, mem_rdata=0x00000000_80000000 -> wdata=0xFFFFFFFF_FFFFFF80; the same data with lbu -> 0x80.
REQ-033 lw: off=4, mem_rdata=0x8765_4321_0000_0000 -> wdata=0xFFFFFFFF_87654321; the same data with lwu -> 0x87654321.
REQ-034 rd=0, wen=1 -> rf_wen=0 and commit=1.
REQ-035 Load with mem_rvalid held 0 for 10 cycles -> in_ready=0 throughout and no commit; rst asserted on cycle 5 -> IDLE, no write, and a later mem_rvalid is ignored.
REQ-036 Back-to-back ALU ops with in_valid=1 held -> one commit every 2 cycles, no lost or duplicated writes.
